// File: rtl/es_imm_encoder_pkg.sv
// Shared definitions for the RV32I immediate encoder.
// Holds the immediate format codes (the same codes the decoder's IMM select
// uses), the RV32I base opcodes, and a helper for signed-range checks.
package es_imm_encoder_pkg;

  // Immediate format codes. Codes 5..7 are invalid.
  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // True when v is representable as a signed value of 'width' bits, i.e.
  // v[31:width-1] are all copies of the same bit. Arithmetic shifting by
  // width-1 leaves all-zeros or all-ones exactly in that case.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned width);
    logic [31:0] shifted;
    shifted = 32'($signed(v) >>> (width - 32'd1));
    return (shifted == 32'h0000_0000) || (shifted == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/es_imm_encoder_pack.sv
// Combinational immediate packer.
// Scatters imm into the bit positions of the selected format on top of base,
// and flags values that the decoder could not reproduce.
// Ports:
//   fmt  - format code (FMT_I..FMT_J, others invalid)
//   base - base instruction word, immediate bits don't-care
//   imm  - immediate value as the decoder must reproduce it
//   word - base with immediate fields overwritten (truncated bits on error)
//   err  - imm out of range / misaligned, or invalid fmt
module es_imm_pack
  import es_imm_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  // Field placement and range check per format.
  always_comb begin
    word = base;
    err  = 1'b0;
    case (fmt)
      FMT_I: begin
        word = {imm[11:0], base[19:0]};
        err  = ~fits_signed(imm, 32'd12);
      end
      FMT_S: begin
        word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        err  = ~fits_signed(imm, 32'd12);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        err  = ~fits_signed(imm, 32'd13) | imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], base[11:0]};
        err  = (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        err  = ~fits_signed(imm, 32'd21) | imm[0];
      end
      default: begin
        // Invalid format: pass the base word through untouched.
        word = base;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/es_imm_encoder.sv
// Pipelined RV32I immediate encoder (write-side inverse of the decoder).
// Accepts {fmt, base, imm} on a valid/ready input, packs the immediate, and
// presents the word one cycle later from a single output register stage,
// tagged with a sequential instruction-memory word address.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - request handshake; in_fmt/in_base/in_imm payload
//   addr_load/addr_in     - load the address counter (wins over increment)
//   out_valid/out_ready   - result handshake
//   out_word/out_addr     - encoded instruction and its word address
//   out_err               - current out_word failed range/format check
//   err_count             - saturating count of erroneous words delivered
module es_imm_encoder
  import es_imm_encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [31:0]       in_base,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  stage_e              state_r;
  stage_e              state_next_s;
  logic [31:0]         word_r;
  logic                err_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ERR_W-1:0]    err_cnt_r;
  logic [31:0]         pack_word_s;
  logic                pack_err_s;
  logic                in_fire_s;
  logic                out_fire_s;

  es_imm_pack u_pack (
    .fmt  (in_fmt),
    .base (in_base),
    .imm  (in_imm),
    .word (pack_word_s),
    .err  (pack_err_s)
  );

  // in_ready depends only on stage state and out_ready, never on in_valid.
  assign out_valid  = (state_r == ST_FULL);
  assign in_ready   = ~out_valid | out_ready;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  assign out_word  = word_r;
  assign out_err   = err_r;
  assign out_addr  = addr_r;
  assign err_count = err_cnt_r;

  // Output stage state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output stage next state: fill on accept, drain on delivery without refill.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire_s && !in_fire_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Output data register: loads only on an input handshake, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r <= 32'h0000_0000;
      err_r  <= 1'b0;
    end else if (in_fire_s) begin
      word_r <= pack_word_s;
      err_r  <= pack_err_s;
    end else begin
      word_r <= word_r;
      err_r  <= err_r;
    end
  end

  // Word address counter: explicit load beats the delivery increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (addr_load) begin
      addr_r <= addr_in;
    end else if (out_fire_s) begin
      addr_r <= addr_r + ADDR_ONE;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Saturating count of erroneous words handed to the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_r <= {ERR_W{1'b0}};
    end else if (out_fire_s && err_r && (err_cnt_r != ERR_MAX)) begin
      err_cnt_r <= err_cnt_r + ERR_ONE;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

endmodule

// File: tb/tb_es_imm_encoder.sv
// Self-checking bench for es_imm_encoder: a vector table pushed through with
// a scoreboard queue, plus directed backpressure, address load/wrap and
// mid-stream reset sequences. A second instance with ERR_W=2 shares the
// stimulus to exercise err_count saturation.
module tb_es_imm_encoder;
  import es_imm_encoder_pkg::*;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [9:0]  addr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [9:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_word2;
  logic [9:0]  out_addr2;
  logic        out_err2;
  logic [1:0]  err_count2;

  int n_vec  = 0;
  int n_miss = 0;

  exp_t       exp_q[$];
  logic [9:0] model_addr = 10'd0;
  logic [7:0] model_err  = 8'd0;
  logic [1:0] model_err2 = 2'd0;

  vec_t vecs[15];

  always #5 clk = ~clk;

  es_imm_encoder #(.ADDR_W(10), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_base(in_base), .in_imm(in_imm),
    .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  es_imm_encoder #(.ADDR_W(10), .ERR_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_base(in_base), .in_imm(in_imm),
    .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid2), .out_ready(out_ready), .out_word(out_word2),
    .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge (inputs are stable for
  // the coming rising edge, outputs reflect the previous one).
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      model_addr = 10'd0;
      model_err  = 8'd0;
      model_err2 = 2'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: got word %h with no expected entry", out_word);
        end else begin
          e = exp_q.pop_front();
          check("out_word", out_word, e.word);
          check("out_err", 32'(out_err), 32'(e.err));
          check("out_addr", 32'(out_addr), 32'(model_addr));
          check("err_count", 32'(err_count), 32'(model_err));
          check("err_count_w2", 32'(err_count2), 32'(model_err2));
          check("out_word_w2", out_word2, e.word);
          if (e.err) begin
            if (model_err != 8'hFF) model_err = model_err + 8'd1;
            if (model_err2 != 2'd3) model_err2 = model_err2 + 2'd1;
          end
        end
        if (addr_load) model_addr = addr_in;
        else model_addr = model_addr + 10'd1;
      end else if (addr_load) begin
        model_addr = addr_in;
      end
    end
  end

  // Present one request and wait (bounded) for it to be accepted.
  task automatic send(input logic [2:0] fmt, input logic [31:0] base, input logic [31:0] imm,
                      input logic [31:0] exp_word, input logic exp_err);
    exp_t e;
    bit   ok = 1'b0;
    in_valid = 1'b1;
    in_fmt   = fmt;
    in_base  = base;
    in_imm   = imm;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin
        e.word = exp_word;
        e.err  = exp_err;
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: in_ready stayed 0 for base %h", base);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{FMT_I, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    vecs[1]  = '{FMT_S, 32'h0020_A023, 32'h0000_0008, 32'h0020_A423, 1'b0};
    vecs[2]  = '{FMT_B, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    vecs[3]  = '{FMT_U, 32'h0000_02B7, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[4]  = '{FMT_J, 32'h0000_00EF, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    vecs[5]  = '{FMT_I, 32'h0000_0093, 32'h0000_0800, 32'h8000_0093, 1'b1};
    vecs[6]  = '{FMT_B, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b1};
    vecs[7]  = '{3'd6,  32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[8]  = '{FMT_S, 32'h0020_A023, 32'h0000_1000, 32'h0020_A023, 1'b1};
    vecs[9]  = '{FMT_U, 32'h0000_02B7, 32'h1234_5001, 32'h1234_52B7, 1'b1};
    vecs[10] = '{FMT_J, 32'h0000_00EF, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0};
    vecs[11] = '{FMT_I, 32'h0000_0093, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    vecs[12] = '{FMT_B, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1};
    vecs[13] = '{FMT_I, 32'h0000_0093, 32'h0000_07FF, 32'h7FF0_0093, 1'b0};
    vecs[14] = '{3'd5,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_fmt    = 3'd0;
    in_base   = 32'h0;
    in_imm    = 32'h0;
    addr_load = 1'b0;
    addr_in   = 10'd0;
    out_ready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // First request: visible one cycle after accept, at address 0.
    send(vecs[0].fmt, vecs[0].base, vecs[0].imm, vecs[0].exp_word, vecs[0].exp_err);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("latency_out_word", out_word, 32'hFFF0_0093);

    // Remaining table back to back with out_ready held high.
    for (int i = 1; i < 15; i++) begin
      send(vecs[i].fmt, vecs[i].base, vecs[i].imm, vecs[i].exp_word, vecs[i].exp_err);
    end
    in_valid = 1'b0;
    drain();
    @(posedge clk);
    #1;
    check("table_err_count", 32'(err_count), 32'd7);
    check("table_err_count_sat", 32'(err_count2), 32'd3);
    check("table_out_addr", 32'(out_addr), 32'd15);

    // Backpressure: held word, address stable and in_ready low.
    out_ready = 1'b0;
    send(FMT_U, 32'h0000_02B7, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_word", out_word, 32'h1234_52B7);
      check("bp_out_addr", 32'(out_addr), 32'd15);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Address load concurrent with an output handshake, then wrap.
    out_ready = 1'b0;
    send(FMT_I, 32'h0000_0093, 32'h0000_0005, 32'h0050_0093, 1'b0);
    in_valid  = 1'b0;
    addr_load = 1'b1;
    addr_in   = 10'd1023;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    check("load_out_valid", 32'(out_valid), 32'd0);
    send(FMT_J, 32'h0000_00EF, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    check("load_out_addr", 32'(out_addr), 32'd1023);
    send(FMT_S, 32'h0020_A023, 32'h0000_0008, 32'h0020_A423, 1'b0);
    check("wrap_out_addr", 32'(out_addr), 32'd0);
    in_valid = 1'b0;
    drain();

    // Reset while FULL discards the held word and clears counters.
    out_ready = 1'b0;
    send(FMT_I, 32'h0000_0093, 32'h0000_1000, 32'h0000_0093, 1'b1);
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_addr", 32'(out_addr), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_out_word", out_word, 32'h0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_stays_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/es_imm_encoder.md
# es_imm_encoder

Pipelined RV32I immediate encoder: the write-side inverse of the immediate decoder. It takes a base instruction word (opcode, funct, and register fields, with immediate bits don't-care), an immediate format code and a 32-bit immediate value. It scatters the immediate into the format's bit positions, range-checks it, and emits the finished word with a sequential instruction-memory word address. It sits between the test/boot program loader and the instruction memory write port, using valid/ready on both sides.

## Interface
Parameters:
- ADDR_W, 10, width of the instruction-memory word address counter
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_fmt  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5..7 invalid (same code as decoder IMM select)
- in_base  input  32  base instruction word
- in_imm  input  32  immediate as the value the decoder must reproduce
- addr_load  input  1  load address counter
- addr_in  input  ADDR_W  value loaded by addr_load
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts when out_valid & out_ready
- out_word  output  32  encoded instruction
- out_addr  output  ADDR_W  word address for out_word
- out_err  output  1  current out_word failed range/format check
- err_count  output  ERR_W  accepted erroneous words, saturating

## Operation
- Field placement overwrites the in_base bits at the immediate positions. All other in_base bits pass unchanged.
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Range check (error when violated):
  - I/S: imm[31:11] all equal
  - B: imm[31:12] all equal and imm[0]=0
  - U: imm[11:0]=0
  - J: imm[31:20] all equal and imm[0]=0
  - fmt 5..7: always error, out_word = in_base
- On error the word is still encoded with the truncated bits and delivered. out_err=1.
- err_count increments on each output handshake with out_err=1 and holds at 2^ERR_W-1.
- Address counter:
  - out_addr increments by 1 on each output handshake and wraps from 2^ADDR_W-1 to 0.
  - addr_load sets the counter to addr_in next cycle.
  - addr_load wins over a simultaneous handshake increment.
  - addr_load does not disturb a held word's data.
- State: one output register stage (EMPTY / FULL, tracked by out_valid).

## Timing
- Reset values: out_valid=0, out_word=0, out_addr=0, out_err=0, err_count=0.
- in_ready=1 in the reset cycle is not required; in_ready is valid from the first cycle after reset.
- in_ready = ~out_valid | out_ready (combinational from out_ready; no combinational path from in_valid).
- Latency: an accepted request appears on out_* the next cycle.
- Throughput: one word per cycle while out_ready=1.
- EMPTY→FULL: on an input handshake.
- FULL→EMPTY: on an output handshake with no input handshake.
- FULL→FULL (reload): on simultaneous output and input handshakes.
- While out_valid=1 & out_ready=0: out_word, out_err and out_addr are stable, and in_ready=0.
- Reset asserted mid-stream: any held word is discarded, and the counters clear the next cycle.

## Structure
- The shared package holds the format code constants (FMT_I..FMT_J), shared with the decoder select logic, plus the RV32I opcode constants.
- One sub-module, es_imm_pack, is natural: it is combinational and maps fmt, base and imm to word and err. The top holds the register stage, address counter and error counter.

## Test plan
- addi x1,x0,-1: base 0x00000093, fmt I, imm 0xFFFFFFFF → out_word 0xFFF00093, out_err 0, out_addr 0, one cycle after accept.
- sw x2,8(x1): base 0x0020A023, fmt S, imm 8 → 0x0020A423.
- beq x0,x0,-4: base 0x00000063, fmt B, imm 0xFFFFFFFC → 0xFE000EE3.
- lui x5 base 0x000002B7, fmt U, imm 0x12345000 → 0x123452B7. Then jal x1 base 0x000000EF, fmt J, imm 0x800 → 0x001000EF at out_addr 1.
- Errors and saturation:
  - fmt I, imm 2048 → out_err 1, err_count 1 after the handshake.
  - fmt B, imm 3 → out_err 1.
  - fmt 6 → out_word = base, out_err 1.
  - ERR_W=2 with 5 errors → err_count 3.
- Backpressure, load and wrap:
  - Hold out_ready=0 for 3 cycles → word and address stable, in_ready 0.
  - addr_load with addr_in=1023 concurrent with a handshake → next out_addr 1023, then 0 after the next handshake (ADDR_W=10).
  - Reset asserted while FULL → out_valid 0 next cycle.
